instr_prefetch: RTL
===================

// Module: instr_prefetch
// PURPOSE
//  Fetch stage feeding the datapath: holds fetch PC, runs req/ack handshake to
//  instruction memory (variable latency), buffers fetched words in a small FIFO,
//  presents {pc,instr} to the datapath under valid/ready. Redirect (branch/jump)
//  flushes the FIFO and restarts fetch at a new PC.
// PARAMETERS
//  DEPTH     4             FIFO entries (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset (word aligned)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-low reset (rst==0 resets)
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  fetch byte address, bits[1:0]==2'b00
//  imem_ack     in   1   memory accepts req and returns data this cycle
//  imem_rdata   in   32  instruction word, valid when imem_ack
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch PC; bits[1:0] forced to 2'b00
//  out_valid    out  1   FIFO head valid
//  out_ready    in   1   datapath consumes head when out_valid&&out_ready
//  out_pc       out  32  PC of head instruction (0 when !out_valid)
//  out_instr    out  32  head instruction word (0 when !out_valid)
//  fifo_count   out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst==0 at edge): fpc=RESET_PC, count=0, pending=0, discard=0;
//    imem_req=0, out_valid=0, out_pc=0, out_instr=0, fifo_count=0.
//  - At most one outstanding request. New request starts (imem_req rises,
//    imem_addr=fpc) only when !pending && count<DEPTH (slot reserved; count can
//    only grow via that request's ack, so push never overflows).
//  - imem_req and imem_addr held stable until the cycle imem_ack==1; ack only
//    meaningful while imem_req==1. Next request may start the cycle after ack.
//  - On ack (not discarded): push {imem_addr,imem_rdata}; fpc<=fpc+4 (mod 2^32,
//    32'hFFFF_FFFC wraps to 0). Data visible on out_* next cycle (latency 1
//    from ack; first fetch: req high in cycle 1 after reset release).
//  - Pop when out_valid&&out_ready; push and pop same cycle: count unchanged.
//  - Full (count==DEPTH): imem_req stays low until a pop.
//  - Redirect: next cycle count=0, out_valid=0, fpc=redirect_pc&~3.
//    If a request is pending and not acked this cycle: keep req/addr stable,
//    set discard; its ack drops data, clears discard, no fpc change.
//    Redirect in the ack cycle: ack data dropped. Redirect beats a same-cycle
//    pop (pop ignored) and a same-cycle push. Back-to-back redirects: last wins.
//  - Reset mid-transaction: request abandoned, imem_req low next cycle;
//    memory side must tolerate abandoned request.
//  - Internal states of fetch FSM: IDLE (no req), REQ (req high, data kept),
//    DROP (req high, data to be discarded).
//    IDLE->REQ: count<DEPTH (no redirect this cycle); REQ->IDLE: ack;
//    REQ->DROP: redirect && !ack; DROP->IDLE: ack; any->IDLE on reset.
// STRUCTURE
//  - Shared package: INSTR_W=32, PC_W=32, PC_STEP=32'd4, RESET_PC default,
//    fetch FSM state enum {IDLE,REQ,DROP}.
//  - One sub-module: fetch_fifo (sync FIFO, DEPTH x 64b, push/pop/flush,
//    count, wrap-around pointers); FSM and fpc live in instr_prefetch.
// TESTING
//  1 Reset release, ack 1 cycle after each req, out_ready=1 -> out_pc 0,4,8,..
//    in order; instr matches memory; out_valid from cycle 3 on.
//  2 out_ready=0, ack immediate -> exactly DEPTH(4) acks, fifo_count=4,
//    imem_req low; one pop -> one further req at addr 16.
//  3 Random 0-5 cycle ack latency, random out_ready -> imem_addr stable
//    while req, stream contiguous, no loss/duplication over 1000 instrs.
//  4 Redirect to 32'h0000_0103 while req pending at 0x8 -> ack data dropped,
//    next req addr 0x100, out_valid low until that word arrives.
//  5 Redirect same cycle as ack and as pop with count=2 -> count 0 next
//    cycle, neither word ever appears on out_*.
//  6 fpc=32'hFFFF_FFFC fetch -> next imem_addr 0; rst=0 mid-request ->
//    imem_req=0, out_valid=0 next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package instr_prefetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [PC_W-1:0] PC_STEP      = 32'd4;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Memory-side and datapath-side signals of the prefetch stage.
interface instr_prefetch_if #(
  parameter int unsigned DEPTH = 4
);
  import instr_prefetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [CW-1:0]      fifo_count;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count,
    input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count,
    output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/instr_prefetch_fetch_fifo.sv
// Synchronous FIFO of {pc,instr} entries with flush; flush overrides push/pop.
module fetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/instr_prefetch.sv
// Fetch stage: single-outstanding imem request FSM, fetch PC and a small
// instruction FIFO presenting {pc,instr} to the datapath.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  instr_prefetch_if.master    bus
);

  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e    state;
  logic [PC_W-1:0] fpc;
  logic            req;
  logic [PC_W-1:0] addr;

  logic            push;
  logic            pop;
  logic            valid;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    wentry;

  // Redirect flushes the FIFO, so it also cancels any same-cycle push or pop.
  assign push   = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign valid  = (count != '0);
  assign pop    = valid && bus.out_ready && !bus.redirect;
  assign wentry = '{pc: addr, instr: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      fpc   <= RESET_PC;
      req   <= 1'b0;
      addr  <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.redirect && (count < FULL)) begin
            state <= REQ;
            req   <= 1'b1;
            addr  <= fpc;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            state <= IDLE;
            req   <= 1'b0;
            if (!bus.redirect) begin
              fpc <= fpc + PC_STEP;
            end
          end else if (bus.redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
      if (bus.redirect) begin
        fpc <= align_pc(bus.redirect_pc);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.out_valid  = valid;
  assign bus.out_pc     = valid ? head.pc : '0;
  assign bus.out_instr  = valid ? head.instr : '0;
  assign bus.fifo_count = count;

endmodule
